// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between fetch and imem.
// Master issues req/addr; slave returns ready and a one-cycle rvalid pulse.
interface fetch_stage_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// IF stage plus IF/ID register: one outstanding imem fetch at a time,
// with a one-entry skid for responses that land during a stall.
module fetch_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                StallF,
  input  logic                FlushD,
  input  logic                PCSrcR,
  input  logic [63:0]         PCTargetR,
  fetch_stage_if.master       imem,
  output logic [31:0]         InstrD,
  output logic [63:0]         PCD,
  output logic [63:0]         PCPlus4D,
  output logic                ValidD
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic        req_q, req_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [63:0] skid_pc_q, skid_pc_d;
  logic [31:0] instrd_q, instrd_d;
  logic [63:0] pcd_q, pcd_d;
  logic [63:0] pcplus4d_q, pcplus4d_d;
  logic        validd_q, validd_d;

  logic [63:0] pc_plus4;
  logic [63:0] target;
  logic        accept;

  assign pc_plus4 = pc_q + 64'd4;
  assign target   = PCTargetR & ~64'h3;
  assign accept   = (state_q == S_REQ) && req_q
                    && imem.imem_ready;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    instrd_d     = instrd_q;
    pcd_d        = pcd_q;
    pcplus4d_d   = pcplus4d_q;
    validd_d     = validd_q;

    unique case (state_q)
      S_REQ: begin
        if (accept) begin
          state_d = S_WAIT;
          kill_d  = PCSrcR;
        end
      end
      S_WAIT: begin
        if (imem.imem_rvalid) begin
          if (kill_q || PCSrcR) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else if (!StallF) begin
            instrd_d   = imem.imem_rdata;
            pcd_d      = pc_q;
            pcplus4d_d = pc_plus4;
            validd_d   = 1'b1;
            pc_d       = pc_plus4;
            state_d    = S_REQ;
          end else begin
            skid_instr_d = imem.imem_rdata;
            skid_pc_d    = pc_q;
            state_d      = S_HOLD;
          end
        end else if (PCSrcR) begin
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (PCSrcR) begin
          state_d = S_REQ;
        end else if (!StallF) begin
          instrd_d     = skid_instr_q;
          pcd_d        = skid_pc_q;
          pcplus4d_d   = skid_pc_q + 64'd4;
          validd_d     = 1'b1;
          pc_d         = pc_plus4;
          skid_instr_d = '0;
          skid_pc_d    = '0;
          state_d      = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    // A bubble replaces whatever was loaded; PCD/PCPlus4D keep old values.
    if (FlushD || PCSrcR) begin
      instrd_d   = NOP_INSTR;
      validd_d   = 1'b0;
      pcd_d      = pcd_q;
      pcplus4d_d = pcplus4d_q;
    end

    if (PCSrcR) begin
      pc_d         = target;
      skid_instr_d = '0;
      skid_pc_d    = '0;
    end

    req_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      req_q        <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      instrd_q     <= NOP_INSTR;
      pcd_q        <= '0;
      pcplus4d_q   <= '0;
      validd_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      req_q        <= req_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      instrd_q     <= instrd_d;
      pcd_q        <= pcd_d;
      pcplus4d_q   <= pcplus4d_d;
      validd_q     <= validd_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign InstrD         = instrd_q;
  assign PCD            = pcd_q;
  assign PCPlus4D       = pcplus4d_q;
  assign ValidD         = validd_q;

endmodule
